// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with stall/done handshake
// Single outstanding request; word-addressed 16-bit array, fixed BUSY latency.

module data_mem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        stall,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic                  ill_q, ill_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [15:0]           dout_q, dout_d;
   logic                  mem_we;
   logic [15:0]           mem_q [2**DEPTH_LOG2];

   // Upper address bits alias onto the array by design.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      ill_d   = ill_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd || wr) begin
               rd_d    = rd;
               wr_d    = wr;
               idx_d   = addr[DEPTH_LOG2:1];
               wdata_d = data_in;
               ill_d   = (rd && wr) || addr[0];
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               mem_we  = wr_q && !ill_q;
               if (rd_q && !ill_q) begin
                  dout_d = mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ill_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 16'd0;
         dout_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ill_q   <= ill_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
      end
   end

   // Array is not reset; a reset landing on the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign stall    = (state_q == BUSY);
   assign done     = (state_q == DONE);
   assign err      = (state_q == DONE) && ill_q;
   assign data_out = dout_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
// Two instances share the clock: LATENCY=2 (main) and LATENCY=1.

module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        rd_a, wr_a, rd_b, wr_b;
   logic [15:0] addr_a, din_a, addr_b, din_b;
   logic [15:0] dout_a, dout_b;
   logic        stall_a, done_a, err_a, stall_b, done_b, err_b;

   logic        sel;
   logic        stall_m, done_m, err_m;
   logic [15:0] dout_m;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .rd(rd_a), .wr(wr_a), .addr(addr_a), .data_in(din_a),
      .data_out(dout_a), .stall(stall_a), .done(done_a), .err(err_a)
   );

   data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .rd(rd_b), .wr(wr_b), .addr(addr_b), .data_in(din_b),
      .data_out(dout_b), .stall(stall_b), .done(done_b), .err(err_b)
   );

   assign stall_m = sel ? stall_b : stall_a;
   assign done_m  = sel ? done_b  : done_a;
   assign err_m   = sel ? err_b   : err_a;
   assign dout_m  = sel ? dout_b  : dout_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
      if (sel) begin
         rd_b = r; wr_b = w; addr_b = a; din_b = d;
      end else begin
         rd_a = r; wr_a = w; addr_a = a; din_a = d;
      end
   endtask

   // One request, dropped after acceptance; checks latency, flags and data_out at done.
   task automatic access(input string tag, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d, input int lat,
                         input logic exp_err, input logic [15:0] exp_dout);
      int n;
      int k;
      @(negedge clk);
      set_req(r, w, a, d);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b0, 1'b0, a, d);
      n = 0;
      k = 0;
      while (!done_m && k < 40) begin
         if (stall_m) n++;
         k++;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done_m), 32'd1);
      check({tag, "_stall_cycles"}, n, lat);
      check({tag, "_err"}, 32'(err_m), 32'(exp_err));
      check({tag, "_stall_at_done"}, 32'(stall_m), 32'd0);
      check({tag, "_dout"}, 32'(dout_m), 32'(exp_dout));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
   endtask

   initial begin
      int k;
      int t1;
      int t2;
      logic seen;
      sel = 1'b0;
      rst = 1'b0;
      rd_a = 0; wr_a = 0; addr_a = 0; din_a = 0;
      rd_b = 0; wr_b = 0; addr_b = 0; din_b = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", 32'(stall_a), 32'd0);
      check("reset_done", 32'(done_a), 32'd0);
      check("reset_err", 32'(err_a), 32'd0);
      check("reset_dout", 32'(dout_a), 32'd0);
      rst = 1'b1;

      access("wr_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2, 1'b0, 16'h0000);
      access("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hBEEF);

      access("wr_1234", 1'b0, 1'b1, 16'h0020, 16'h1234, 2, 1'b0, 16'hBEEF);
      access("rdwr_ill", 1'b1, 1'b1, 16'h0020, 16'h9999, 2, 1'b1, 16'hBEEF);
      access("rd_1234", 1'b1, 1'b0, 16'h0020, 16'h0000, 2, 1'b0, 16'h1234);

      access("wr_unalign", 1'b0, 1'b1, 16'h0011, 16'hFFFF, 2, 1'b1, 16'h1234);
      access("rd_after_ua", 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 1'b0, 16'hBEEF);
      access("rd_unalign", 1'b1, 1'b0, 16'h0013, 16'h0000, 2, 1'b1, 16'hBEEF);

      access("wr_alias", 1'b0, 1'b1, 16'h0202, 16'h5A5A, 2, 1'b0, 16'hBEEF);
      access("rd_alias", 1'b1, 1'b0, 16'h0002, 16'h0000, 2, 1'b0, 16'h5A5A);

      // Reset during the first BUSY cycle must drop the pending write.
      access("wr_1111", 1'b0, 1'b1, 16'h0030, 16'h1111, 2, 1'b0, 16'h5A5A);
      @(negedge clk);
      set_req(1'b0, 1'b1, 16'h0030, 16'hAAAA);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
      check("abort_busy", 32'(stall_a), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check("abort_stall", 32'(stall_a), 32'd0);
      check("abort_done", 32'(done_a), 32'd0);
      check("abort_err", 32'(err_a), 32'd0);
      check("abort_dout", 32'(dout_a), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen = seen | done_a;
         @(negedge clk);
      end
      check("abort_no_done", 32'(seen), 32'd0);
      access("rd_after_abort", 1'b1, 1'b0, 16'h0030, 16'h0000, 2, 1'b0, 16'h1111);

      // Back-to-back reads with rd held high through done.
      access("wr_0c0c", 1'b0, 1'b1, 16'h0000, 16'h0C0C, 2, 1'b0, 16'h1111);
      @(negedge clk);
      set_req(1'b1, 1'b0, 16'h0000, 16'h0000);
      k = 0;
      while (!done_a && k < 40) begin k++; @(negedge clk); end
      check("b2b_first_done", 32'(done_a), 32'd1);
      check("b2b_first_dout", 32'(dout_a), 32'h0C0C);
      t1 = cyc;
      set_req(1'b1, 1'b0, 16'h0002, 16'h0000);
      @(negedge clk);
      check("b2b_gap_idle", 32'(stall_a | done_a), 32'd0);
      k = 0;
      while (!done_a && k < 40) begin k++; @(negedge clk); end
      t2 = cyc;
      check("b2b_second_done", 32'(done_a), 32'd1);
      check("b2b_spacing", t2 - t1, 4);
      check("b2b_second_dout", 32'(dout_a), 32'h5A5A);
      set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      check("b2b_settled", 32'(stall_a | done_a), 32'd0);

      sel = 1'b1;
      access("l1_wr_beef", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1, 1'b0, 16'h0000);
      access("l1_rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 1, 1'b0, 16'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
